// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB slave holding 15 R/W 32-bit registers plus a read-only ID word at index 15.
// Latency: setup + access (two cycles) per transfer; with `APB_SLV_WAIT_EN, WAIT_CYC wait states are inserted.
// Backpressure: PREADY is constant 1 unless `APB_SLV_WAIT_EN is defined, then it is low during wait states.
module apb_slave_regfile #(
  parameter int SLV_IDX  = 0,
  parameter int WAIT_CYC = 2
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [3:0]  PSELx,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [15:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PSLVERR,
  output logic        PREADY,
  output logic [7:0]  viol_cnt
);

  localparam logic [1:0]  SLV_BIT = SLV_IDX[1:0];
  localparam logic [31:0] ID_VAL  = 32'hA5B2_0000 | {30'd0, SLV_BIT};

  // Catch out-of-range parameters at elaboration rather than silently aliasing.
  if (SLV_IDX < 0 || SLV_IDX > 3) begin : g_bad_slv_idx
    $error("apb_slave_regfile: SLV_IDX must be 0..3");
  end
  if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait_cyc
    $error("apb_slave_regfile: WAIT_CYC must be 1..15");
  end

`ifdef APB_SLV_WAIT_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2
  } state_t;
  localparam logic [3:0] WAIT_LD = WAIT_CYC[3:0];
`else
  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;
`endif

  state_t      r_state;
  state_t      w_state_nxt;

  logic        w_sel;
  logic [3:0]  w_idx;
  logic        w_dec_err;
  logic        w_match;
  logic        w_pready;
  logic        w_setup;
  logic        w_commit;
  logic        w_done;
  logic        w_viol;
  logic [31:0] w_rd_val;

  logic [31:0] r_regs [0:14];
  logic [15:0] r_addr;
  logic        r_write;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_prdata;
  logic        r_pslverr;
  logic [7:0]  r_viol_cnt;

`ifdef APB_SLV_WAIT_EN
  logic [3:0]  r_wait_cnt;
`endif

  // Only our own select bit matters; the other PSELx lines belong to sibling slaves.
  assign w_sel = PSELx[SLV_BIT];
  assign w_idx = PADDR[5:2];

  // Out-of-window address, misaligned address, or write to the read-only ID word.
  assign w_dec_err = (PADDR[15:6] != 10'd0) || (PADDR[1:0] != 2'd0) ||
                     (PWRITE && (w_idx == 4'hF));

  // Access phase is legitimate only while the master holds the transfer it set up.
  assign w_match = w_sel && PENABLE && (PADDR == r_addr) && (PWRITE == r_write);

`ifdef APB_SLV_WAIT_EN
  assign w_pready = (r_wait_cnt == 4'd0);
  assign PSLVERR  = r_pslverr & w_pready;
`else
  assign w_pready = 1'b1;
  assign PSLVERR  = r_pslverr;
`endif

  assign PREADY   = w_pready;
  assign PRDATA   = r_prdata;
  assign viol_cnt = r_viol_cnt;

  // Read mux: index 15 returns the ID word, everything else the register array.
  always_comb begin
    w_rd_val = ID_VAL;
    for (int i = 0; i < 15; i++) begin
      if (w_idx == 4'(i)) begin
        w_rd_val = r_regs[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and per-edge control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_setup     = 1'b0;
    w_commit    = 1'b0;
    w_done      = 1'b0;
    w_viol      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sel && !PENABLE) begin
          w_setup = 1'b1;
`ifdef APB_SLV_WAIT_EN
          w_state_nxt = S_WAIT;
`else
          w_state_nxt = S_ACCESS;
`endif
        end else if (w_sel && PENABLE) begin
          // Access phase with no setup: drop it, count it.
          w_viol = 1'b1;
        end
      end
`ifdef APB_SLV_WAIT_EN
      S_WAIT: begin
        if (w_match) begin
          if (r_wait_cnt == 4'd1) begin
            w_state_nxt = S_ACCESS;
          end
        end else begin
          w_viol      = 1'b1;
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
`endif
      S_ACCESS: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
        if (w_match && w_pready) begin
          w_commit = r_write && !r_err;
        end else begin
          w_viol = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Capture the request at the setup edge so the access phase can be checked against it.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_addr  <= 16'd0;
      r_write <= 1'b0;
      r_wdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_setup) begin
      r_addr  <= PADDR;
      r_write <= PWRITE;
      r_wdata <= PWDATA;
      r_err   <= w_dec_err;
    end
  end

  // Read data and error are registered at setup so they are stable for the whole access phase.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_prdata  <= 32'd0;
      r_pslverr <= 1'b0;
    end else if (w_setup) begin
      r_prdata  <= (!PWRITE && !w_dec_err) ? w_rd_val : 32'd0;
      r_pslverr <= w_dec_err;
    end else if (w_done) begin
      r_prdata  <= 32'd0;
      r_pslverr <= 1'b0;
    end
  end

  // Register array: writes land on the completion edge, visible to the very next setup.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < 15; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (w_commit) begin
      for (int i = 0; i < 15; i++) begin
        if (r_addr[5:2] == 4'(i)) begin
          r_regs[i] <= r_wdata;
        end
      end
    end
  end

  // Saturating protocol-violation counter.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_viol_cnt <= 8'd0;
    end else if (w_viol && (r_viol_cnt != 8'hFF)) begin
      r_viol_cnt <= r_viol_cnt + 8'd1;
    end
  end

`ifdef APB_SLV_WAIT_EN
  // Wait-state counter: loaded at setup, counts down while the master holds the transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wait_cnt <= 4'd0;
    end else if (w_setup) begin
      r_wait_cnt <= WAIT_LD;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= w_match ? (r_wait_cnt - 4'd1) : 4'd0;
    end
  end
`endif

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: table-driven APB transfers scored through an expectation queue,
// followed by hand-written violation, saturation, select-isolation and reset sequences.
// Works for both builds; wait-state length is checked only when APB_SLV_WAIT_EN is defined.
module tb_apb_slave_regfile;

  localparam int         SLV    = 2;
  localparam int         WCYC   = 2;
  localparam logic [3:0] SEL_ME = 4'(1 << SLV);

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [3:0]  PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PSLVERR;
  logic        PREADY;
  logic [7:0]  viol_cnt;

  always #5 PCLK = ~PCLK;

  apb_slave_regfile #(.SLV_IDX(SLV), .WAIT_CYC(WCYC)) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .PSELx    (PSELx),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PSLVERR  (PSLVERR),
    .PREADY   (PREADY),
    .viol_cnt (viol_cnt)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add_vec(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
    vecs.push_back('{wr: wr, addr: addr, wdata: wdata, exp_rdata: exp_rdata, exp_err: exp_err});
  endtask

  // One full transfer; returns at the negedge of the final access cycle, completion edge pending.
  task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err, input string name);
    exp_t e;
    int   waits;
    @(posedge PCLK); #1;
    PSELx   = SEL_ME;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = wdata;
    sb_q.push_back('{rdata: exp_rd, err: exp_err});
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0;
    @(negedge PCLK);
    while (PREADY !== 1'b1 && waits < 40) begin
      @(negedge PCLK);
      waits++;
    end
    e = sb_q.pop_front();
    chk({name, "_pready"}, {31'd0, PREADY}, 32'd1);
`ifdef APB_SLV_WAIT_EN
    chk({name, "_waits"}, 32'(waits), 32'(WCYC));
`endif
    chk({name, "_prdata"}, PRDATA, e.rdata);
    chk({name, "_pslverr"}, {31'd0, PSLVERR}, {31'd0, e.err});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge PCLK); #1;
      PSELx   = 4'd0;
      PENABLE = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn = 1'b0;
    PSELx   = 4'd0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = 16'd0;
    PWDATA  = 32'd0;

    // Vectors run back-to-back: each setup follows the previous completion edge directly.
    add_vec(1'b1, 16'h0008, 32'hDEAD_BEEF, 32'h0,          1'b0);
    add_vec(1'b0, 16'h0008, 32'h0,         32'hDEAD_BEEF,  1'b0);
    add_vec(1'b0, 16'h003C, 32'h0,         32'hA5B2_0002,  1'b0);
    add_vec(1'b1, 16'h003C, 32'h1234_5678, 32'h0,          1'b1);
    add_vec(1'b0, 16'h003C, 32'h0,         32'hA5B2_0002,  1'b0);
    add_vec(1'b0, 16'h0040, 32'h0,         32'h0,          1'b1);
    add_vec(1'b0, 16'h0006, 32'h0,         32'h0,          1'b1);
    add_vec(1'b1, 16'h0000, 32'h1111_1111, 32'h0,          1'b0);
    add_vec(1'b1, 16'h0038, 32'hCAFE_F00D, 32'h0,          1'b0);
    add_vec(1'b0, 16'h0000, 32'h0,         32'h1111_1111,  1'b0);
    add_vec(1'b0, 16'h0038, 32'h0,         32'hCAFE_F00D,  1'b0);
    add_vec(1'b1, 16'h0044, 32'hFFFF_FFFF, 32'h0,          1'b1);
    add_vec(1'b1, 16'h0002, 32'hAAAA_AAAA, 32'h0,          1'b1);
    add_vec(1'b0, 16'h0004, 32'h0,         32'h0,          1'b0);
    add_vec(1'b0, 16'h0000, 32'h0,         32'h1111_1111,  1'b0);

    // Reset values while reset is held.
    #12;
    chk("rst_prdata",  PRDATA, 32'h0);
    chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    chk("rst_pready",  {31'd0, PREADY}, 32'd1);
    chk("rst_viol",    {24'd0, viol_cnt}, 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    idle(2);

    for (int i = 0; i < vecs.size(); i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err,
           $sformatf("vec%0d", i));
    end
    idle(1);
    @(negedge PCLK);
    chk("table_viol", {24'd0, viol_cnt}, 32'd0);
    chk("table_idle_prdata", PRDATA, 32'h0);

    // Address changes between setup and access: abort, no write, one violation.
    @(posedge PCLK); #1;
    PSELx = SEL_ME; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0004; PWDATA = 32'h5555_5555;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PADDR = 16'h0008;
    @(posedge PCLK); #1;
    PSELx = 4'd0; PENABLE = 1'b0;
    @(negedge PCLK);
    chk("abort_viol", {24'd0, viol_cnt}, 32'd1);
    chk("abort_prdata", PRDATA, 32'h0);
    xfer(1'b0, 16'h0004, 32'h0, 32'h0, 1'b0, "abort_r4");
    xfer(1'b0, 16'h0008, 32'h0, 32'hDEAD_BEEF, 1'b0, "abort_r8");
    idle(1);

    // Access phase with no setup while idle: ignored, counted.
    @(posedge PCLK); #1;
    PSELx = SEL_ME; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 16'h0004; PWDATA = 32'h6666_6666;
    @(posedge PCLK); #1;
    PSELx = 4'd0; PENABLE = 1'b0;
    @(negedge PCLK);
    chk("nosetup_viol", {24'd0, viol_cnt}, 32'd2);
    xfer(1'b0, 16'h0004, 32'h0, 32'h0, 1'b0, "nosetup_r4");
    idle(1);

    // A full transfer addressed to the other slaves must not touch this one.
    @(posedge PCLK); #1;
    PSELx = ~SEL_ME; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0004; PWDATA = 32'h7777_7777;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    chk("othersel_prdata", PRDATA, 32'h0);
    idle(1);
    @(negedge PCLK);
    chk("othersel_viol", {24'd0, viol_cnt}, 32'd2);
    xfer(1'b0, 16'h0004, 32'h0, 32'h0, 1'b0, "othersel_r4");
    idle(1);

    // 300 no-setup violations: count climbs, then sticks at 8'hFF.
    @(posedge PCLK); #1;
    PSELx = SEL_ME; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 16'h0000;
    repeat (100) @(posedge PCLK);
    #1;
    PSELx = 4'd0; PENABLE = 1'b0;
    @(negedge PCLK);
    chk("sat_mid", {24'd0, viol_cnt}, 32'd102);
    @(posedge PCLK); #1;
    PSELx = SEL_ME; PENABLE = 1'b1;
    repeat (200) @(posedge PCLK);
    #1;
    PSELx = 4'd0; PENABLE = 1'b0;
    @(negedge PCLK);
    chk("sat_ff", {24'd0, viol_cnt}, 32'h0000_00FF);
    xfer(1'b0, 16'h0008, 32'h0, 32'hDEAD_BEEF, 1'b0, "sat_r8");
    idle(1);
    @(negedge PCLK);
    chk("sat_hold", {24'd0, viol_cnt}, 32'h0000_00FF);

    // Reset pulsed during the access phase of a write: transfer discarded, all state cleared.
    @(posedge PCLK); #1;
    PSELx = SEL_ME; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0010; PWDATA = 32'h1234_5678;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b0;
    PSELx = 4'd0; PENABLE = 1'b0;
    #1;
    chk("midrst_prdata",  PRDATA, 32'h0);
    chk("midrst_pslverr", {31'd0, PSLVERR}, 32'd0);
    chk("midrst_pready",  {31'd0, PREADY}, 32'd1);
    chk("midrst_viol",    {24'd0, viol_cnt}, 32'd0);
    #3;
    PRESETn = 1'b1;
    idle(1);
    xfer(1'b0, 16'h0010, 32'h0, 32'h0, 1'b0, "midrst_r10");
    xfer(1'b0, 16'h0008, 32'h0, 32'h0, 1'b0, "midrst_r8");
    xfer(1'b0, 16'h003C, 32'h0, 32'hA5B2_0002, 1'b0, "midrst_id");
    idle(1);
    @(negedge PCLK);
    chk("end_viol", {24'd0, viol_cnt}, 32'd0);
    chk("end_sbq_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
